// File: rtl/sti_pixel_streamer.sv
// rtl/sti_pixel_streamer.sv - unpacks the packed sti ROM image into a 1 pixel/clk raster stream
module sti_pixel_streamer #(
    parameter int WORDS   = 1024,
    parameter int WORD_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int PADDR_W = 14,
    parameter int PIX_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               sti_rd,
    output logic [ADDR_W-1:0]  sti_addr,
    input  logic [WORD_W-1:0]  sti_di,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [PIX_W-1:0]   pix_data,
    output logic [PADDR_W-1:0] pix_addr,
    output logic               pix_last
);
    localparam int BIT_W = $clog2(WORD_W);
    localparam logic [PADDR_W-1:0] LAST_PIX = PADDR_W'(WORDS * WORD_W - 1);
    localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [ADDR_W:0]    WORDS_L  = (ADDR_W + 1)'(WORDS);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_STREAM, S_FIN} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   sh_q, sh_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [PADDR_W-1:0]  pix_addr_q, pix_addr_d;
    logic                pix_valid_q, pix_valid_d;
    logic                pix_last_q, pix_last_d;
    logic [WORD_W-1:0]   pf_data_q, pf_data_d;
    logic                pf_full_q, pf_full_d;
    logic                pend_q, pend_d;
    logic [ADDR_W:0]     next_word_q, next_word_d;
    logic                sti_rd_q, sti_rd_d;
    logic [ADDR_W-1:0]   sti_addr_q, sti_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hs;
    logic                underrun;

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        bit_cnt_d   = bit_cnt_q;
        pix_addr_d  = pix_addr_q;
        pix_valid_d = pix_valid_q;
        pix_last_d  = pix_last_q;
        pf_data_d   = pf_data_q;
        pf_full_d   = pf_full_q;
        pend_d      = sti_rd_q;
        next_word_d = next_word_q;
        sti_rd_d    = 1'b0;
        sti_addr_d  = sti_addr_q;
        underrun    = 1'b0;
        hs          = pix_valid_q & pix_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FETCH;
                    sti_rd_d    = 1'b1;
                    sti_addr_d  = '0;
                    next_word_d = (ADDR_W + 1)'(1);
                    pix_addr_d  = '0;
                    pf_full_d   = 1'b0;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                sh_d        = sti_di;
                bit_cnt_d   = '0;
                pix_valid_d = 1'b1;
                pix_last_d  = (pix_addr_q == LAST_PIX);
                state_d     = S_STREAM;
            end
            S_STREAM: begin
                if (pend_q) begin
                    pf_data_d = sti_di;
                    pf_full_d = 1'b1;
                end
                if (!pf_full_q && !sti_rd_q && !pend_q && (next_word_q < WORDS_L)) begin
                    sti_rd_d    = 1'b1;
                    sti_addr_d  = next_word_q[ADDR_W-1:0];
                    next_word_d = next_word_q + (ADDR_W + 1)'(1);
                end
                if (hs) begin
                    if (pix_last_q) begin
                        pix_valid_d = 1'b0;
                        pix_last_d  = 1'b0;
                        state_d     = S_FIN;
                    end else begin
                        pix_addr_d = pix_addr_q + PADDR_W'(1);
                        pix_last_d = ((pix_addr_q + PADDR_W'(1)) == LAST_PIX);
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            // Swap in the prefetched word on the same edge so the stream has no bubble
                            if (pf_full_q) begin
                                sh_d      = pf_data_q;
                                pf_full_d = 1'b0;
                            end else begin
                                pix_valid_d = 1'b0;
                                underrun    = 1'b1;
                            end
                        end else begin
                            sh_d = {sh_q[WORD_W-2:0], 1'b0};
                        end
                    end
                end else if (!pix_valid_q && pf_full_q) begin
                    sh_d        = pf_data_q;
                    pf_full_d   = 1'b0;
                    pix_valid_d = 1'b1;
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sh_q        <= '0;
            bit_cnt_q   <= '0;
            pix_addr_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            pf_data_q   <= '0;
            pf_full_q   <= 1'b0;
            pend_q      <= 1'b0;
            next_word_q <= '0;
            sti_rd_q    <= 1'b0;
            sti_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            bit_cnt_q   <= bit_cnt_d;
            pix_addr_q  <= pix_addr_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
            pf_data_q   <= pf_data_d;
            pf_full_q   <= pf_full_d;
            pend_q      <= pend_d;
            next_word_q <= next_word_d;
            sti_rd_q    <= sti_rd_d;
            sti_addr_q  <= sti_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // With a 1-cycle ROM the prefetch always lands long before the word boundary
    assert property (@(posedge clk) disable iff (reset) !underrun);

    assign busy      = busy_q;
    assign done      = done_q;
    assign sti_rd    = sti_rd_q;
    assign sti_addr  = sti_addr_q;
    assign pix_valid = pix_valid_q;
    assign pix_data  = {{(PIX_W-1){1'b0}}, sh_q[WORD_W-1]};
    assign pix_addr  = pix_addr_q;
    assign pix_last  = pix_last_q;
endmodule

// File: tb/tb_sti_pixel_streamer.sv
// tb/tb_sti_pixel_streamer.sv - randomized self-checking bench for sti_pixel_streamer
module tb_sti_pixel_streamer;
    localparam int WORDS = 1024;
    localparam int NPIX  = 16384;

    logic        clk = 1'b0;
    logic        reset, start, pix_ready;
    logic [15:0] sti_di = '0;
    logic        busy, done, sti_rd, pix_valid, pix_last;
    logic [9:0]  sti_addr;
    logic [7:0]  pix_data;
    logic [13:0] pix_addr;

    sti_pixel_streamer dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .sti_rd(sti_rd), .sti_addr(sti_addr), .sti_di(sti_di),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_addr(pix_addr), .pix_last(pix_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] rom [WORDS];
    always @(posedge clk) if (sti_rd) sti_di <= rom[sti_addr];

    logic [13:0] got_addr [NPIX];
    logic [7:0]  got_data [NPIX];
    logic        got_last [NPIX];
    int hs_n, rd_n, rd_addr_err, lat, done_n, done_cyc, first_hs, last_hs;
    int busy_err, stab_err, post_act, rd_hold_in, rd_hold_out, timeout, first_bad;
    int total = 0;
    int bad = 0;

    // Reference: pixel k is bit (15 - k%16) of ROM word k/16, zero-extended
    function automatic logic [7:0] exp_pix(input int k);
        logic [15:0] w;
        w = rom[k / 16];
        return {7'b0, w[15 - (k % 16)]};
    endfunction

    function automatic int count_mism(input int n);
        int m = 0;
        for (int k = 0; k < n; k++) begin
            if (got_addr[k] !== 14'(k) || got_data[k] !== exp_pix(k) || got_last[k] !== (k == NPIX - 1)) begin
                if (m == 0) first_bad = k;
                m++;
            end
        end
        return m;
    endfunction

    task automatic run_stream(input int ready_pct, input int hold_at, input int hold_len,
                              input int reset_at, input int start_at, input bit start_in_fin);
        int hold_cnt, t0;
        bit stall, start_done, r;
        logic [7:0] pd;
        logic [13:0] pa;
        logic pl;
        hs_n = 0; rd_n = 0; rd_addr_err = 0; lat = -1; done_n = 0; done_cyc = -1;
        first_hs = -1; last_hs = -1; busy_err = 0; stab_err = 0; post_act = 0;
        rd_hold_in = -1; rd_hold_out = -1; timeout = 0; first_bad = -1;
        hold_cnt = 0; stall = 0; start_done = 0; pd = '0; pa = '0; pl = 1'b0;
        @(negedge clk); start = 1'b1; t0 = cyc;
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < 50000; n++) begin
            if (sti_rd) begin
                if (sti_addr !== 10'(rd_n)) rd_addr_err++;
                rd_n++;
            end
            if (pix_valid && lat < 0) lat = cyc - t0;
            if (busy !== 1'b1) busy_err++;
            if (stall && (pix_valid !== 1'b1 || pix_data !== pd || pix_addr !== pa || pix_last !== pl))
                stab_err++;
            if (done) begin
                done_n++; done_cyc = cyc;
                break;
            end
            if (reset_at >= 0 && hs_n == reset_at) begin
                pix_ready = 1'b0; reset = 1'b1;
                @(negedge clk); reset = 1'b0;
                return;
            end
            if (hold_at >= 0 && hs_n == hold_at && hold_cnt < hold_len) begin
                if (hold_cnt == 0) rd_hold_in = rd_n;
                hold_cnt++;
                r = 1'b0;
                if (hold_cnt == hold_len) rd_hold_out = rd_n;
            end else begin
                r = ($urandom_range(0, 99) < ready_pct);
            end
            if (start_at >= 0 && !start_done && hs_n >= start_at) begin
                start = 1'b1; start_done = 1'b1;
            end else begin
                start = 1'b0;
            end
            pix_ready = r;
            if (pix_valid && r) begin
                got_addr[hs_n] = pix_addr; got_data[hs_n] = pix_data; got_last[hs_n] = pix_last;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                hs_n++;
            end
            stall = pix_valid && !r;
            pd = pix_data; pa = pix_addr; pl = pix_last;
            @(negedge clk);
        end
        if (done_n == 0) timeout = 1;
        pix_ready = 1'b0;
        start = start_in_fin;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy || sti_rd || pix_valid || done) post_act++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; pix_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (sti_rd !== 1'b0) begin bad++; $display("FAIL reset_sti_rd: got %b want 0", sti_rd); end
        total++; if (sti_addr !== 10'd0) begin bad++; $display("FAIL reset_sti_addr: got %0d want 0", sti_addr); end
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL reset_pix_valid: got %b want 0", pix_valid); end
        total++; if (pix_data !== 8'd0) begin bad++; $display("FAIL reset_pix_data: got %0d want 0", pix_data); end
        total++; if (pix_addr !== 14'd0) begin bad++; $display("FAIL reset_pix_addr: got %0d want 0", pix_addr); end
        total++; if (pix_last !== 1'b0) begin bad++; $display("FAIL reset_pix_last: got %b want 0", pix_last); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_bits;
        int m;
        for (int i = 0; i < WORDS; i++) rom[i] = 16'h0000;
        rom[0] = 16'h8001;
        run_stream(100, -1, 0, -1, -1, 1'b0);
        total++; if (lat !== 3) begin bad++; $display("FAIL first_valid_latency: got %0d want 3", lat); end
        total++; if (hs_n !== NPIX) begin bad++; $display("FAIL single_hs_count: got %0d want %0d", hs_n, NPIX); end
        total++; if (got_data[0] !== 8'd1) begin bad++; $display("FAIL pix0: got %0d want 1", got_data[0]); end
        total++; if (got_data[15] !== 8'd1) begin bad++; $display("FAIL pix15: got %0d want 1", got_data[15]); end
        total++; if (got_data[1] !== 8'd0) begin bad++; $display("FAIL pix1: got %0d want 0", got_data[1]); end
        total++; if (got_data[16] !== 8'd0) begin bad++; $display("FAIL pix16: got %0d want 0", got_data[16]); end
        m = count_mism(hs_n);
        total++; if (m !== 0) begin bad++; $display("FAIL single_stream: %0d bad pixels (first %0d) want 0", m, first_bad); end
    endtask

    task automatic test_full_frame;
        int m;
        for (int i = 0; i < WORDS; i++) rom[i] = 16'($urandom);
        run_stream(100, -1, 0, -1, 100, 1'b1);
        total++; if (timeout !== 0) begin bad++; $display("FAIL full_timeout: got %0d want 0", timeout); end
        total++; if (hs_n !== NPIX) begin bad++; $display("FAIL full_hs_count: got %0d want %0d", hs_n, NPIX); end
        total++; if (last_hs - first_hs !== NPIX - 1) begin bad++; $display("FAIL full_consecutive: got span %0d want %0d", last_hs - first_hs, NPIX - 1); end
        total++; if (done_cyc - last_hs !== 1) begin bad++; $display("FAIL done_delay: got %0d want 1", done_cyc - last_hs); end
        total++; if (rd_n !== WORDS) begin bad++; $display("FAIL rd_pulses: got %0d want %0d", rd_n, WORDS); end
        total++; if (rd_addr_err !== 0) begin bad++; $display("FAIL rd_addr_order: got %0d errors want 0", rd_addr_err); end
        total++; if (busy_err !== 0) begin bad++; $display("FAIL busy_during_frame: got %0d low cycles want 0", busy_err); end
        total++; if (done_n !== 1) begin bad++; $display("FAIL done_count: got %0d want 1", done_n); end
        total++; if (post_act !== 0) begin bad++; $display("FAIL start_in_fin_ignored: got %0d active cycles want 0", post_act); end
        m = count_mism(hs_n);
        total++; if (m !== 0) begin bad++; $display("FAIL full_stream: %0d bad pixels (first %0d) want 0", m, first_bad); end
    endtask

    task automatic test_random_ready;
        int m;
        for (int i = 0; i < WORDS; i++) rom[i] = 16'(i);
        run_stream(50, -1, 0, -1, -1, 1'b0);
        total++; if (hs_n !== NPIX) begin bad++; $display("FAIL rand_hs_count: got %0d want %0d", hs_n, NPIX); end
        total++; if (stab_err !== 0) begin bad++; $display("FAIL rand_stable: got %0d changes want 0", stab_err); end
        total++; if (rd_n !== WORDS) begin bad++; $display("FAIL rand_rd_pulses: got %0d want %0d", rd_n, WORDS); end
        m = count_mism(hs_n);
        total++; if (m !== 0) begin bad++; $display("FAIL rand_stream: %0d bad pixels (first %0d) want 0", m, first_bad); end
    endtask

    task automatic test_word_boundary_hold;
        int m;
        for (int i = 0; i < WORDS; i++) rom[i] = 16'($urandom);
        run_stream(100, 15, 40, 64, -1, 1'b0);
        total++; if (rd_hold_in !== 2) begin bad++; $display("FAIL hold_rd_before: got %0d want 2", rd_hold_in); end
        total++; if (rd_hold_out !== 2) begin bad++; $display("FAIL hold_rd_after: got %0d want 2", rd_hold_out); end
        total++; if (stab_err !== 0) begin bad++; $display("FAIL hold_stable: got %0d changes want 0", stab_err); end
        total++; if (got_data[16] !== exp_pix(16)) begin bad++; $display("FAIL hold_pix16: got %0d want %0d", got_data[16], exp_pix(16)); end
        m = count_mism(hs_n);
        total++; if (m !== 0 || hs_n !== 64) begin bad++; $display("FAIL hold_stream: %0d bad of %0d want 0 of 64", m, hs_n); end
    endtask

    task automatic test_reset_midframe;
        int m;
        for (int i = 0; i < WORDS; i++) rom[i] = 16'($urandom);
        run_stream(100, -1, 0, 5000, -1, 1'b0);
        total++; if (hs_n !== 5000) begin bad++; $display("FAIL pre_reset_hs: got %0d want 5000", hs_n); end
        total++; if (pix_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL after_reset_idle: got valid=%b busy=%b want 0 0", pix_valid, busy); end
        for (int i = 0; i < WORDS; i++) rom[i] = 16'($urandom);
        run_stream(100, -1, 0, 400, -1, 1'b0);
        total++; if (lat !== 3) begin bad++; $display("FAIL restart_latency: got %0d want 3", lat); end
        total++; if (got_addr[0] !== 14'd0) begin bad++; $display("FAIL restart_addr0: got %0d want 0", got_addr[0]); end
        total++; if (rd_addr_err !== 0) begin bad++; $display("FAIL restart_rd_order: got %0d errors want 0", rd_addr_err); end
        m = count_mism(hs_n);
        total++; if (m !== 0 || hs_n !== 400) begin bad++; $display("FAIL restart_stream: %0d bad of %0d want 0 of 400", m, hs_n); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pix_ready = 1'b0;
        test_reset;
        test_single_bits;
        test_full_frame;
        test_random_ready;
        test_word_boundary_hold;
        test_reset_midframe;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
